// File: rtl/bfp_to_fp_norm_4lane_if.sv
// Bundle of handshake and data signals between the PE accumulator bank,
// the BFP-to-FP normalizer and the output writeback.
//   master : the producer/consumer environment around the normalizer
//            (drives in_valid/in_acc/in_exp and out_ready)
//   slave  : the normalizer itself (drives in_ready and all out_* signals)
interface bfp_to_fp_norm_4lane_if #(
    parameter int ACC_WIDTH = 16,
    parameter int EXP_WIDTH = 6,
    parameter int MAN_WIDTH = 8
);
    logic                             in_valid;
    logic                             in_ready;
    logic [3:0][ACC_WIDTH-1:0]        in_acc;
    logic [EXP_WIDTH-1:0]             in_exp;
    logic                             out_valid;
    logic                             out_ready;
    logic [3:0]                       out_sign;
    logic [3:0][EXP_WIDTH-1:0]        out_exp;
    logic [3:0][MAN_WIDTH-1:0]        out_man;
    logic [3:0]                       out_zero;
    logic [3:0]                       out_ovf;

    modport master (
        output in_valid, in_acc, in_exp, out_ready,
        input  in_ready, out_valid, out_sign, out_exp, out_man, out_zero, out_ovf
    );

    modport slave (
        input  in_valid, in_acc, in_exp, out_ready,
        output in_ready, out_valid, out_sign, out_exp, out_man, out_zero, out_ovf
    );
endinterface

// File: rtl/bfp_to_fp_norm_4lane.sv
// Converts four signed fixed-point accumulators that share one block
// exponent into per-lane sign / exponent / normalized mantissa.
// Two register stages with valid/ready flow control:
//   stage 1 : sign, magnitude, leading-one position, shared exponent
//   stage 2 : exponent rebias, mantissa alignment, zero/underflow/overflow
// Ports:
//   clk   : rising-edge clock
//   rst_n : synchronous active-low reset, clears both stage-valid bits
//   bus   : slave side of bfp_to_fp_norm_4lane_if (input beat, output beat)
module bfp_to_fp_norm_4lane #(
    parameter int ACC_WIDTH = 16,
    parameter int EXP_WIDTH = 6,
    parameter int MAN_WIDTH = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    bfp_to_fp_norm_4lane_if.slave   bus
);

    localparam int PW = $clog2(ACC_WIDTH);
    // Signed width wide enough for in_exp + p - (ACC_WIDTH-2) without wrap.
    localparam int EW = EXP_WIDTH + PW + 1;

    function automatic logic [PW-1:0] lead_one(input logic [ACC_WIDTH-1:0] v);
        logic [PW-1:0] pos;
        pos = '0;
        for (int k = 0; k < ACC_WIDTH; k++) begin
            if (v[k]) pos = PW'(k);
        end
        return pos;
    endfunction

    // stage 1 state
    logic                        s1_valid;
    logic [3:0]                  s1_sign;
    logic [3:0][ACC_WIDTH-1:0]   s1_m;
    logic [3:0][PW-1:0]          s1_p;
    logic [3:0]                  s1_nz;
    logic [EXP_WIDTH-1:0]        s1_exp;

    // stage 2 (output) state
    logic                        s2_valid;
    logic [3:0]                  s2_sign;
    logic [3:0][EXP_WIDTH-1:0]   s2_exp;
    logic [3:0][MAN_WIDTH-1:0]   s2_man;
    logic [3:0]                  s2_zero;
    logic [3:0]                  s2_ovf;

    logic s1_adv;
    logic in_fire;

    assign s1_adv       = !s2_valid || bus.out_ready;
    assign bus.in_ready = !s1_valid || s1_adv;
    assign in_fire      = bus.in_valid && bus.in_ready;

    assign bus.out_valid = s2_valid;
    assign bus.out_sign  = s2_sign;
    assign bus.out_exp   = s2_exp;
    assign bus.out_man   = s2_man;
    assign bus.out_zero  = s2_zero;
    assign bus.out_ovf   = s2_ovf;

    // stage 1 combinational: magnitude and leading-one search
    logic [3:0][ACC_WIDTH-1:0] m_c;
    logic [3:0][PW-1:0]        p_c;

    always_comb begin
        m_c = '0;
        p_c = '0;
        for (int i = 0; i < 4; i++) begin
            // Negating the most negative value yields 2^(ACC_WIDTH-1), which is
            // exactly representable as an unsigned magnitude.
            m_c[i] = bus.in_acc[i][ACC_WIDTH-1] ? (~bus.in_acc[i] + ACC_WIDTH'(1))
                                                : bus.in_acc[i];
            p_c[i] = lead_one(m_c[i]);
        end
    end

    // stage 2 combinational: rebias, align, classify
    logic [3:0]                n_sign;
    logic [3:0][EXP_WIDTH-1:0] n_exp;
    logic [3:0][MAN_WIDTH-1:0] n_man;
    logic [3:0]                n_zero;
    logic [3:0]                n_ovf;
    logic [EW-1:0]             e_c;
    logic [ACC_WIDTH-1:0]      sh_c;

    always_comb begin
        n_sign = '0;
        n_exp  = '0;
        n_man  = '0;
        n_zero = '0;
        n_ovf  = '0;
        e_c    = '0;
        sh_c   = '0;
        for (int i = 0; i < 4; i++) begin
            e_c = EW'(s1_exp) + EW'(s1_p[i]) - EW'(ACC_WIDTH - 2);
            if (s1_p[i] >= PW'(MAN_WIDTH - 1))
                sh_c = s1_m[i] >> (s1_p[i] - PW'(MAN_WIDTH - 1));
            else
                sh_c = s1_m[i] << (PW'(MAN_WIDTH - 1) - s1_p[i]);

            if (!s1_nz[i] || e_c[EW-1]) begin
                // true zero or underflow flush: all fields cleared
                n_zero[i] = 1'b1;
            end else if (|e_c[EW-2:EXP_WIDTH]) begin
                n_sign[i] = s1_sign[i];
                n_exp[i]  = '1;
                n_man[i]  = '1;
                n_ovf[i]  = 1'b1;
            end else begin
                n_sign[i] = s1_sign[i];
                n_exp[i]  = e_c[EXP_WIDTH-1:0];
                n_man[i]  = sh_c[MAN_WIDTH-1:0];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_sign  <= '0;
            s1_m     <= '0;
            s1_p     <= '0;
            s1_nz    <= '0;
            s1_exp   <= '0;
            s2_valid <= 1'b0;
            s2_sign  <= '0;
            s2_exp   <= '0;
            s2_man   <= '0;
            s2_zero  <= '0;
            s2_ovf   <= '0;
        end else begin
            if (bus.in_ready) begin
                s1_valid <= bus.in_valid;
            end
            if (in_fire) begin
                for (int i = 0; i < 4; i++) begin
                    s1_sign[i] <= bus.in_acc[i][ACC_WIDTH-1];
                    s1_nz[i]   <= |m_c[i];
                end
                s1_m   <= m_c;
                s1_p   <= p_c;
                s1_exp <= bus.in_exp;
            end
            if (s1_adv) begin
                s2_valid <= s1_valid;
            end
            // Output fields only change when a new beat enters stage 2, so
            // they stay stable through a stall.
            if (s1_adv && s1_valid) begin
                s2_sign <= n_sign;
                s2_exp  <= n_exp;
                s2_man  <= n_man;
                s2_zero <= n_zero;
                s2_ovf  <= n_ovf;
            end
        end
    end

endmodule

// File: tb/tb_bfp_to_fp_norm_4lane.sv
module tb_bfp_to_fp_norm_4lane;

    logic clk;
    logic rst_n;

    bfp_to_fp_norm_4lane_if #(.ACC_WIDTH(16), .EXP_WIDTH(6), .MAN_WIDTH(8)) bus ();

    bfp_to_fp_norm_4lane #(.ACC_WIDTH(16), .EXP_WIDTH(6), .MAN_WIDTH(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_vec++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s got=%h want=%h", tag, got, want);
        end
    endtask

    // lane word = {sign, exp[5:0], man[7:0], zero, ovf}
    function automatic logic [16:0] pk(input bit s, input int e, input int m,
                                       input bit z, input bit o);
        return {s, 6'(e), 8'(m), z, o};
    endfunction

    function automatic logic [16:0] lane_word(input int l);
        return {bus.out_sign[l], bus.out_exp[l], bus.out_man[l],
                bus.out_zero[l], bus.out_ovf[l]};
    endfunction

    logic [15:0] t_acc  [8][4];
    logic [5:0]  t_exp  [8];
    logic [16:0] t_want [8][4];

    initial begin
        // in_exp=20 normal conversion
        t_exp[0] = 6'd20;
        t_acc[0] = '{16'h4000, 16'h00FF, 16'h0003, 16'hFED4};
        t_want[0] = '{pk(0,20,8'h80,0,0), pk(0,13,8'hFF,0,0), pk(0,7,8'hC0,0,0), pk(1,14,8'h96,0,0)};
        // in_exp=63 boundaries
        t_exp[1] = 6'd63;
        t_acc[1] = '{16'h8000, 16'h0000, 16'h0001, 16'h4000};
        t_want[1] = '{pk(1,63,8'hFF,0,1), pk(0,0,0,1,0), pk(0,49,8'h80,0,0), pk(0,63,8'h80,0,0)};
        // in_exp=3 underflow; 0x0800 lands exactly on e=0, still representable
        t_exp[2] = 6'd3;
        t_acc[2] = '{16'h0001, 16'h0800, 16'h1000, 16'hFFFF};
        t_want[2] = '{pk(0,0,0,1,0), pk(0,0,8'h80,0,0), pk(0,1,8'h80,0,0), pk(0,0,0,1,0)};
        t_exp[3] = 6'd10;
        t_acc[3] = '{16'h7FFF, 16'hFFFE, 16'h0100, 16'h8001};
        t_want[3] = '{pk(0,10,8'hFF,0,0), pk(0,0,0,1,0), pk(0,4,8'h80,0,0), pk(1,10,8'hFF,0,0)};
        t_exp[4] = 6'd0;
        t_acc[4] = '{16'h4000, 16'h7FFF, 16'h2000, 16'h0000};
        t_want[4] = '{pk(0,0,8'h80,0,0), pk(0,0,8'hFF,0,0), pk(0,0,0,1,0), pk(0,0,0,1,0)};
        t_exp[5] = 6'd50;
        t_acc[5] = '{16'h0081, 16'hFF7F, 16'h1234, 16'h0005};
        t_want[5] = '{pk(0,43,8'h81,0,0), pk(1,43,8'h81,0,0), pk(0,48,8'h91,0,0), pk(0,38,8'hA0,0,0)};
        t_exp[6] = 6'd62;
        t_acc[6] = '{16'h4000, 16'h7FFF, 16'hC000, 16'h0040};
        t_want[6] = '{pk(0,62,8'h80,0,0), pk(0,62,8'hFF,0,0), pk(1,62,8'h80,0,0), pk(0,54,8'h80,0,0)};
        t_exp[7] = 6'd49;
        t_acc[7] = '{16'h8000, 16'h00AA, 16'h0001, 16'h5555};
        t_want[7] = '{pk(1,50,8'h80,0,0), pk(0,42,8'hAA,0,0), pk(0,35,8'h80,0,0), pk(0,49,8'hAA,0,0)};
    end

    task automatic drive_beat(input int k);
        for (int i = 0; i < 4; i++) bus.in_acc[i] = t_acc[k][i];
        bus.in_exp = t_exp[k];
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk({tag, "_valid"}, 32'(bus.out_valid), 32'd0);
        for (int i = 0; i < 4; i++)
            chk($sformatf("%s_lane%0d", tag, i), 32'(lane_word(i)), 32'd0);
    endtask

    // Streams table entries [start, start+nb) and checks every output beat in
    // order. bp=1 applies the out_ready pattern; bp=0 holds out_ready high and
    // also checks that the run takes exactly nb+2 cycles.
    task automatic stream(input int start, input int nb, input bit bp);
        bit          pat [8] = '{1, 0, 0, 1, 1, 0, 1, 1};
        int          sent = 0, got = 0, cyc = 0, inflight = 0;
        bit          push, pop, was_stall = 0;
        logic [16:0] held [4];
        while (got < nb && cyc < 200) begin
            @(negedge clk);
            bus.in_valid = (sent < nb);
            if (sent < nb) drive_beat(start + sent);
            bus.out_ready = bp ? pat[cyc % 8] : 1'b1;
            #1;
            chk($sformatf("in_ready_c%0d", cyc), 32'(bus.in_ready),
                32'(!(inflight == 2 && !bus.out_ready)));
            if (was_stall) begin
                for (int i = 0; i < 4; i++)
                    chk($sformatf("hold_c%0d_l%0d", cyc, i), 32'(lane_word(i)), 32'(held[i]));
            end
            push = bus.in_valid && bus.in_ready;
            pop  = bus.out_valid && bus.out_ready;
            was_stall = bus.out_valid && !bus.out_ready;
            for (int i = 0; i < 4; i++) held[i] = lane_word(i);
            if (pop) begin
                for (int i = 0; i < 4; i++)
                    chk($sformatf("beat%0d_lane%0d", start + got, i),
                        32'(lane_word(i)), 32'(t_want[start + got][i]));
                got++;
            end
            if (push) sent++;
            inflight = inflight + int'(push) - int'(pop);
            cyc++;
        end
        bus.in_valid = 1'b0;
        if (got < nb) chk("stream_timeout", 32'(got), 32'(nb));
        else if (!bp) chk($sformatf("cycles_%0d_beats", nb), 32'(cyc), 32'(nb + 2));
    endtask

    initial begin
        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.in_acc    = '0;
        bus.in_exp    = '0;
        repeat (3) @(posedge clk);
        @(negedge clk); #1;
        chk_idle_outputs("reset");
        chk("reset_in_ready", 32'(bus.in_ready), 32'd1);
        rst_n = 1'b1;

        // single beats: the three directed vectors, latency 2
        for (int k = 0; k < 3; k++) stream(k, 1, 1'b0);

        // fill both stages under backpressure, then reset mid-flight
        @(negedge clk);
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        drive_beat(0);
        @(negedge clk);
        drive_beat(1);
        @(negedge clk);
        bus.in_valid = 1'b0;
        #1;
        chk("full_in_ready", 32'(bus.in_ready), 32'd0);
        chk("full_out_valid", 32'(bus.out_valid), 32'd1);
        chk("full_head", 32'(lane_word(3)), 32'(t_want[0][3]));
        rst_n = 1'b0;
        @(negedge clk); #1;
        chk_idle_outputs("midrst");
        chk("midrst_in_ready", 32'(bus.in_ready), 32'd1);
        rst_n = 1'b1;
        bus.out_ready = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk); #1;
            chk($sformatf("post_rst_valid_c%0d", c), 32'(bus.out_valid), 32'd0);
        end

        // 8 beats with a stop/go out_ready pattern
        stream(0, 8, 1'b1);
        // 8 beats at full throughput
        stream(0, 8, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
